// File: rtl/registers_unit.sv
// RV32I integer register file: 32 x XLEN, two combinational read ports with write bypass, one write port.
// Optional debug read port (committed state, no bypass) enabled by defining REGISTERS_UNIT_DBG_EN.
module registers_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SP_IDX  = 2,
   parameter logic [XLEN-1:0] SP_INIT = XLEN'(1024)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RUWr,
   input  logic [4:0]      Rs1,
   input  logic [4:0]      Rs2,
   input  logic [4:0]      Rd,
   input  logic [XLEN-1:0] DataWr,
   output logic [XLEN-1:0] RURs1,
`ifdef REGISTERS_UNIT_DBG_EN
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
`endif
   output logic [XLEN-1:0] RURs2
);

   // Power-up and reset image: everything zero except the stack pointer.
   localparam logic [31:0][XLEN-1:0] REGS_INIT = (32*XLEN)'(SP_INIT) << (SP_IDX*XLEN);

   logic [31:0][XLEN-1:0] regs = REGS_INIT;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs <= REGS_INIT;
      end else if (RUWr && (Rd != 5'd0)) begin
         regs[Rd] <= DataWr;
      end
   end

   // Reads see this cycle's write data before the edge; x0 always reads zero.
   always_comb begin
      RURs1 = regs[Rs1];
      if (Rs1 == 5'd0) begin
         RURs1 = '0;
      end else if (RUWr && (Rd == Rs1)) begin
         RURs1 = DataWr;
      end
   end

   always_comb begin
      RURs2 = regs[Rs2];
      if (Rs2 == 5'd0) begin
         RURs2 = '0;
      end else if (RUWr && (Rd == Rs2)) begin
         RURs2 = DataWr;
      end
   end

`ifdef REGISTERS_UNIT_DBG_EN
   always_comb begin
      dbg_data = regs[dbg_addr];
      if (dbg_addr == 5'd0) begin
         dbg_data = '0;
      end
   end
`else
   // Without the debug build only the two architectural read ports exist.
`endif

endmodule

// File: tb/tb_registers_unit.sv
// Self-checking bench for registers_unit: directed steps followed by randomized traffic
// compared against an array-based reference model of the register file.
module tb_registers_unit;

   localparam int XLEN = 32;

   logic            clk    = 1'b0;
   logic            rst_n  = 1'b1;
   logic            RUWr   = 1'b0;
   logic [4:0]      Rs1    = 5'd0;
   logic [4:0]      Rs2    = 5'd0;
   logic [4:0]      Rd     = 5'd0;
   logic [XLEN-1:0] DataWr = '0;
   logic [XLEN-1:0] RURs1;
   logic [XLEN-1:0] RURs2;
`ifdef REGISTERS_UNIT_DBG_EN
   logic [4:0]      dbg_addr = 5'd0;
   logic [XLEN-1:0] dbg_data;
`endif

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] model [32];

   always #5 clk = ~clk;

   registers_unit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RUWr    (RUWr),
      .Rs1     (Rs1),
      .Rs2     (Rs2),
      .Rd      (Rd),
      .DataWr  (DataWr),
      .RURs1   (RURs1),
`ifdef REGISTERS_UNIT_DBG_EN
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data),
`endif
      .RURs2   (RURs2)
   );

   task automatic modelReset();
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[2] = 32'd1024;
   endtask

   // Architectural read rule: x0 is zero, then same-cycle write data, then storage.
   function automatic logic [XLEN-1:0] expRead(input logic [4:0] addr);
      if (addr == 5'd0) return '0;
      if (RUWr && (Rd == addr)) return DataWr;
      return model[addr];
   endfunction

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstn, input logic we, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] wa,
                                input logic [XLEN-1:0] data);
      @(negedge clk);
      rst_n  = rstn;
      RUWr   = we;
      Rs1    = a1;
      Rs2    = a2;
      Rd     = wa;
      DataWr = data;
      #1;
   endtask

   task automatic clockEdge();
      @(posedge clk);
      if (!rst_n) modelReset();
      else if (RUWr && (Rd != 5'd0)) model[Rd] = DataWr;
      #1;
   endtask

   initial begin
      logic [4:0]      r1;
      logic [4:0]      r2;
      logic [4:0]      wa;
      logic [XLEN-1:0] wd;
      logic            we;
      logic            rn;

      modelReset();

      // Power-up contents, no reset applied yet.
      #1;
      checkOutput("pwrup_x0_p1", RURs1, 32'd0);
      checkOutput("pwrup_x0_p2", RURs2, 32'd0);
      Rs1 = 5'd2;
      #1;
      checkOutput("pwrup_sp", RURs1, 32'd1024);

      applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'd123);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
      checkOutput("write_x5", RURs1, 32'd123);

      applyStimulus(1'b1, 1'b1, 5'd10, 5'd0, 5'd10, 32'd999);
      checkOutput("bypass_x10", RURs1, 32'd999);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 32'd0);
      checkOutput("stored_x10", RURs1, 32'd999);

      applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'd777);
      checkOutput("x0_no_bypass", RURs1, 32'd0);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      checkOutput("x0_after_write", RURs1, 32'd0);

      applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd7, 32'd55);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0);
      checkOutput("write_x7", RURs1, 32'd55);
      applyStimulus(1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 32'd88);
      checkOutput("bypass_in_reset", RURs1, 32'd88);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd7, 5'd2, 5'd0, 32'd0);
      checkOutput("reset_wins_x7", RURs1, 32'd0);
      checkOutput("reset_sp", RURs2, 32'd1024);
      applyStimulus(1'b1, 1'b0, 5'd5, 5'd10, 5'd0, 32'd0);
      checkOutput("reset_x5", RURs1, 32'd0);
      checkOutput("reset_x10", RURs2, 32'd0);

      applyStimulus(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'hDEADBEEF);
      checkOutput("dual_bypass_p1", RURs1, 32'hDEADBEEF);
      checkOutput("dual_bypass_p2", RURs2, 32'hDEADBEEF);
      clockEdge();
      applyStimulus(1'b1, 1'b1, 5'd3, 5'd4, 5'd4, 32'd1234);
      checkOutput("x3_no_bypass", RURs1, 32'hDEADBEEF);
      checkOutput("x4_bypass", RURs2, 32'd1234);
      clockEdge();
      applyStimulus(1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'd0);
      checkOutput("x3_held", RURs1, 32'hDEADBEEF);
      checkOutput("x4_stored", RURs2, 32'd1234);

      $display("[TB] starting randomized traffic");
      for (int n = 0; n < 400; n++) begin
         rn = ($urandom_range(0, 24) != 0);
         we = ($urandom_range(0, 3) != 0);
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
`ifdef REGISTERS_UNIT_DBG_EN
         dbg_addr = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
`endif
         applyStimulus(rn, we, r1, r2, wa, wd);
         checkOutput("rand_p1", RURs1, expRead(Rs1));
         checkOutput("rand_p2", RURs2, expRead(Rs2));
`ifdef REGISTERS_UNIT_DBG_EN
         checkOutput("rand_dbg", dbg_data, (dbg_addr == 5'd0) ? '0 : model[dbg_addr]);
`endif
         clockEdge();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
